// File: rtl/bg_pkg.sv
// Shared definitions for the background-mean estimator: one-hot state encoding,
// pixel width and the saturating pixel conversion.
package bg_pkg;

  localparam int PIXEL_W   = 8;
  localparam int PIXEL_MAX = 255;

  // Bit positions match the Q flag order {Qd, Qb, Qg, Qr, Qa, Qi}.
  typedef enum logic [5:0] {
    ST_IDLE  = 6'b000001,
    ST_ACCUM = 6'b000010,
    ST_DIV_R = 6'b000100,
    ST_DIV_G = 6'b001000,
    ST_DIV_B = 6'b010000,
    ST_DONE  = 6'b100000
  } state_t;

  function automatic logic [PIXEL_W-1:0] sat_pixel(input logic [63:0] q);
    return (q > 64'(PIXEL_MAX)) ? PIXEL_W'(PIXEL_MAX) : q[PIXEL_W-1:0];
  endfunction

endpackage

// File: rtl/serial_div.sv
// Restoring divider, one quotient bit per cycle, MSB first; DVD_W cycles per
// division. quotient is the final value in the cycle where done is high.
module serial_div #(
  parameter int DVD_W = 11,
  parameter int DVS_W = 3
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [DVD_W-1:0] quotient
);

  localparam int CNT_W = $clog2(DVD_W + 1);

  logic [DVD_W-1:0] dvd_q, quo_q, src_dvd, src_quo, quo_nx;
  logic [DVS_W-1:0] rem_q, src_rem, rem_nx;
  logic [DVS_W:0]   trial, diff;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q, load, step, last, fits;

  // The first step works directly on the incoming dividend so no load cycle is spent.
  assign load    = start && !busy_q;
  assign step    = load || busy_q;
  assign src_dvd = load ? dividend : dvd_q;
  assign src_rem = load ? '0 : rem_q;
  assign src_quo = load ? '0 : quo_q;

  assign trial  = {src_rem, src_dvd[DVD_W-1]};
  assign fits   = (trial >= {1'b0, divisor});
  assign diff   = trial - {1'b0, divisor};
  assign rem_nx = fits ? diff[DVS_W-1:0] : trial[DVS_W-1:0];
  assign quo_nx = {src_quo[DVD_W-2:0], fits};

  assign last     = busy_q ? (cnt_q == CNT_W'(DVD_W - 1)) : (DVD_W == 1);
  assign done     = step && last;
  assign busy     = busy_q;
  assign quotient = quo_nx;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      dvd_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (step) begin
      dvd_q  <= src_dvd << 1;
      quo_q  <= quo_nx;
      rem_q  <= rem_nx;
      cnt_q  <= busy_q ? cnt_q + CNT_W'(1) : CNT_W'(1);
      busy_q <= !last;
    end
  end

endmodule

// File: rtl/bg_mean_estimator.sv
// Background-mean estimator: accumulates NUM_SUMS partial channel sums, then
// divides each channel by NUM_SUMS*PIXELS_PER_SUM. `BG_MEAN_ROUND_EN adds TOTAL/2 for round-half-up.
module bg_mean_estimator
  import bg_pkg::*;
#(
  parameter int NUM_SUMS       = 4,
  parameter int PIXELS_PER_SUM = 1,
  parameter int SUM_W          = 8
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic             sum_valid,
  input  logic [SUM_W-1:0] red_sum,
  input  logic [SUM_W-1:0] green_sum,
  input  logic [SUM_W-1:0] blue_sum,
  input  logic             Ack,
  output logic [7:0]       red_exp,
  output logic [7:0]       green_exp,
  output logic [7:0]       blue_exp,
  output logic             Done,
  output logic             Qi,
  output logic             Qa,
  output logic             Qr,
  output logic             Qg,
  output logic             Qb,
  output logic             Qd
);

  localparam int ACC_W = SUM_W + $clog2(NUM_SUMS) + 1;
  localparam int TOTAL = NUM_SUMS * PIXELS_PER_SUM;
  localparam int DVS_W = $clog2(TOTAL + 1);
  localparam int CNT_W = $clog2(NUM_SUMS + 1);
`ifdef BG_MEAN_ROUND_EN
  localparam int BIAS = TOTAL / 2;
`else
  localparam int BIAS = 0;
`endif

  // Handshake: Start is a level sampled only in IDLE; sum_valid qualifies one
  // partial sum per cycle only in ACCUM; Done stays high until Ack is seen in DONE.
  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_r, acc_g, acc_b, bias_add, div_dividend, div_quo;
  logic [CNT_W-1:0] sum_cnt;
  logic             last_sum, div_start, div_busy, div_done;

  assign last_sum = (sum_cnt == CNT_W'(NUM_SUMS - 1));
  assign bias_add = last_sum ? ACC_W'(BIAS) : '0;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    div_start = 1'b0;
    case (state_q)
      ST_IDLE:  if (Start) state_d = ST_ACCUM;
      ST_ACCUM: if (sum_valid && last_sum) state_d = ST_DIV_R;
      ST_DIV_R: begin
        div_start = !div_busy;
        if (div_done) state_d = ST_DIV_G;
      end
      ST_DIV_G: begin
        div_start = !div_busy;
        if (div_done) state_d = ST_DIV_B;
      end
      ST_DIV_B: begin
        div_start = !div_busy;
        if (div_done) state_d = ST_DONE;
      end
      ST_DONE:  if (Ack) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    case (state_q)
      ST_DIV_G: div_dividend = acc_g;
      ST_DIV_B: div_dividend = acc_b;
      default:  div_dividend = acc_r;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      acc_r     <= '0;
      acc_g     <= '0;
      acc_b     <= '0;
      sum_cnt   <= '0;
      red_exp   <= '0;
      green_exp <= '0;
      blue_exp  <= '0;
    end else begin
      if (state_q == ST_IDLE && Start) begin
        acc_r   <= '0;
        acc_g   <= '0;
        acc_b   <= '0;
        sum_cnt <= '0;
      end else if (state_q == ST_ACCUM && sum_valid) begin
        acc_r   <= acc_r + ACC_W'(red_sum) + bias_add;
        acc_g   <= acc_g + ACC_W'(green_sum) + bias_add;
        acc_b   <= acc_b + ACC_W'(blue_sum) + bias_add;
        sum_cnt <= sum_cnt + CNT_W'(1);
      end
      if (div_done) begin
        case (state_q)
          ST_DIV_R: red_exp   <= sat_pixel(64'(div_quo));
          ST_DIV_G: green_exp <= sat_pixel(64'(div_quo));
          ST_DIV_B: blue_exp  <= sat_pixel(64'(div_quo));
          default: ;
        endcase
      end
    end
  end

  serial_div #(
    .DVD_W(ACC_W),
    .DVS_W(DVS_W)
  ) u_div (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (DVS_W'(TOTAL)),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quo)
  );

  assign {Qd, Qb, Qg, Qr, Qa, Qi} = state_q;
  assign Done = Qd;

endmodule

// File: tb/tb_bg_mean_estimator.sv
// Bench for bg_mean_estimator: three parameterisations driven in lockstep,
// an edge-counting mean model compared every cycle, plus literal spot checks.
module tb_bg_mean_estimator;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b1;
  logic        Start, sum_valid, Ack;
  logic [15:0] rs, gs, bs;
  logic [7:0]  er [3];
  logic [7:0]  eg [3];
  logic [7:0]  eb [3];
  logic [6:0]  fl [3];
  bit          chk_en = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;

  typedef struct {
    string  name;
    longint act;
    longint exp;
  } lit_t;
  lit_t lit_q[$];

  always #5 Clk = ~Clk;

  bg_mean_estimator #(.NUM_SUMS(4), .PIXELS_PER_SUM(1), .SUM_W(8)) u_a (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .sum_valid(sum_valid),
    .red_sum(rs[7:0]), .green_sum(gs[7:0]), .blue_sum(bs[7:0]), .Ack(Ack),
    .red_exp(er[0]), .green_exp(eg[0]), .blue_exp(eb[0]), .Done(fl[0][6]),
    .Qi(fl[0][0]), .Qa(fl[0][1]), .Qr(fl[0][2]), .Qg(fl[0][3]), .Qb(fl[0][4]), .Qd(fl[0][5]));

  bg_mean_estimator #(.NUM_SUMS(4), .PIXELS_PER_SUM(64), .SUM_W(14)) u_b (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .sum_valid(sum_valid),
    .red_sum(rs[13:0]), .green_sum(gs[13:0]), .blue_sum(bs[13:0]), .Ack(Ack),
    .red_exp(er[1]), .green_exp(eg[1]), .blue_exp(eb[1]), .Done(fl[1][6]),
    .Qi(fl[1][0]), .Qa(fl[1][1]), .Qr(fl[1][2]), .Qg(fl[1][3]), .Qb(fl[1][4]), .Qd(fl[1][5]));

  bg_mean_estimator #(.NUM_SUMS(4), .PIXELS_PER_SUM(1), .SUM_W(10)) u_c (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .sum_valid(sum_valid),
    .red_sum(rs[9:0]), .green_sum(gs[9:0]), .blue_sum(bs[9:0]), .Ack(Ack),
    .red_exp(er[2]), .green_exp(eg[2]), .blue_exp(eb[2]), .Done(fl[2][6]),
    .Qi(fl[2][0]), .Qa(fl[2][1]), .Qr(fl[2][2]), .Qg(fl[2][3]), .Qb(fl[2][4]), .Qd(fl[2][5]));

  // ---------------- reference model ----------------
  function automatic int sw(input int i);
    return (i == 1) ? 14 : ((i == 2) ? 10 : 8);
  endfunction
  function automatic int aw(input int i);
    return sw(i) + 3;  // SUM_W + clog2(4) + 1
  endfunction
  function automatic longint total(input int i);
    return (i == 1) ? 256 : 4;
  endfunction
  function automatic longint bias(input int i);
`ifdef BG_MEAN_ROUND_EN
    return total(i) / 2;
`else
    return 0;
`endif
  endfunction
  function automatic longint sv(input logic [15:0] x, input int i);
    return longint'(x) & ((longint'(1) << sw(i)) - 1);
  endfunction
  function automatic int mean(input longint a, input int i);
    longint q;
    q = a / total(i);
    return (q > 255) ? 255 : int'(q);
  endfunction

  // model states: 0 idle, 1 accumulating, 2 dividing, 3 done
  int     m_st [3];
  int     m_cnt [3];
  int     m_tick [3];
  longint m_ar [3];
  longint m_ag [3];
  longint m_ab [3];
  int     m_er [3];
  int     m_eg [3];
  int     m_eb [3];

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < 3; i++) begin
        m_st[i] <= 0; m_cnt[i] <= 0; m_tick[i] <= 0;
        m_ar[i] <= 0; m_ag[i] <= 0; m_ab[i] <= 0;
        m_er[i] <= 0; m_eg[i] <= 0; m_eb[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        case (m_st[i])
          0: if (Start) begin
            m_st[i] <= 1; m_cnt[i] <= 0;
            m_ar[i] <= 0; m_ag[i] <= 0; m_ab[i] <= 0;
          end
          1: if (sum_valid) begin
            m_ar[i] <= m_ar[i] + sv(rs, i) + ((m_cnt[i] == 3) ? bias(i) : 0);
            m_ag[i] <= m_ag[i] + sv(gs, i) + ((m_cnt[i] == 3) ? bias(i) : 0);
            m_ab[i] <= m_ab[i] + sv(bs, i) + ((m_cnt[i] == 3) ? bias(i) : 0);
            if (m_cnt[i] == 3) begin
              m_st[i] <= 2; m_tick[i] <= 0;
            end else begin
              m_cnt[i] <= m_cnt[i] + 1;
            end
          end
          2: begin
            m_tick[i] <= m_tick[i] + 1;
            if (m_tick[i] + 1 == aw(i))     m_er[i] <= mean(m_ar[i], i);
            if (m_tick[i] + 1 == 2 * aw(i)) m_eg[i] <= mean(m_ag[i], i);
            if (m_tick[i] + 1 == 3 * aw(i)) begin
              m_eb[i] <= mean(m_ab[i], i);
              m_st[i] <= 3;
            end
          end
          default: if (Ack) m_st[i] <= 0;
        endcase
      end
    end
  end

  function automatic logic [6:0] exp_fl(input int i);
    logic dv;
    dv = (m_st[i] == 2);
    return {m_st[i] == 3, m_st[i] == 3,
            dv && m_tick[i] >= 2 * aw(i),
            dv && m_tick[i] >= aw(i) && m_tick[i] < 2 * aw(i),
            dv && m_tick[i] < aw(i),
            m_st[i] == 1, m_st[i] == 0};
  endfunction

  // ---------------- compare process ----------------
  initial begin
    lit_t   l;
    logic [23:0] want;
    forever begin
      @(negedge Clk);
      if (chk_en) begin
        for (int i = 0; i < 3; i++) begin
          n_checks++;
          if (fl[i] !== exp_fl(i)) begin
            n_fail++;
            $display("FAIL flags[%0d] t=%0t got=%b want=%b", i, $time, fl[i], exp_fl(i));
          end
          want = {8'(m_er[i]), 8'(m_eg[i]), 8'(m_eb[i])};
          n_checks++;
          if ({er[i], eg[i], eb[i]} !== want) begin
            n_fail++;
            $display("FAIL exp[%0d] t=%0t got=%h want=%h", i, $time, {er[i], eg[i], eb[i]}, want);
          end
        end
      end
      while (lit_q.size() > 0) begin
        l = lit_q.pop_front();
        n_checks++;
        if (l.act != l.exp) begin
          n_fail++;
          $display("FAIL %s got=%0d want=%0d", l.name, l.act, l.exp);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic post(input string n, input longint act, input longint exp);
    lit_t l;
    l.name = n; l.act = act; l.exp = exp;
    lit_q.push_back(l);
  endtask

  function automatic logic [3:0][15:0] v4(input int a, input int b, input int c, input int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  task automatic begin_est;
    @(negedge Clk); Start = 1'b1;
    @(negedge Clk); Start = 1'b0;
  endtask

  // pat[j] is sum_valid for step j (steps beyond 6 are valid); Start pulses at step start_at.
  task automatic send(input logic [3:0][15:0] r, input logic [3:0][15:0] g,
                      input logic [3:0][15:0] b, input logic [6:0] pat, input int start_at);
    int  k;
    int  j;
    logic v;
    k = 0; j = 0;
    while (k < 4) begin
      v = (j < 7) ? pat[j] : 1'b1;
      sum_valid = v;
      Start = (j == start_at);
      if (v) begin
        rs = r[k]; gs = g[k]; bs = b[k];
        k++;
      end
      @(negedge Clk);
      j++;
    end
    sum_valid = 1'b0; Start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    bit all_done;
    lat = -1; all_done = 1'b0;
    for (int k = 1; k <= 200 && !all_done; k++) begin
      @(posedge Clk); #1;
      if (fl[0][6] && lat < 0) lat = k;
      all_done = fl[0][6] && fl[1][6] && fl[2][6];
    end
    if (!all_done) post("done_timeout", 0, 1);
  endtask

  task automatic ack;
    @(negedge Clk); Ack = 1'b1;
    @(negedge Clk); Ack = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    Start = 1'b0; sum_valid = 1'b0; Ack = 1'b0; rs = '0; gs = '0; bs = '0;
    #1 Reset_n = 1'b0;
    #1 chk_en = 1'b1;
    post("rst_qi", fl[0][0], 1);
    post("rst_done", fl[0][6], 0);
    post("rst_red", er[0], 0);
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;

    // Basic run: means 25, 0, 255; Done 33 edges after the last sum.
    begin_est();
    send(v4(10, 20, 30, 40), v4(0, 0, 0, 0), v4(255, 255, 255, 255), 7'h7f, -1);
    wait_done(lat);
    post("latency", lat, 33);
    post("t1_red", er[0], 25);
    post("t1_green", eg[0], 0);
    post("t1_blue", eb[0], 255);
    ack();

    // Rounding sensitivity: 103/4 and 101/4.
    begin_est();
    send(v4(10, 20, 30, 43), v4(0, 0, 0, 0), v4(0, 0, 0, 0), 7'h7f, -1);
    wait_done(lat);
`ifdef BG_MEAN_ROUND_EN
    post("r103_red", er[0], 26);
`else
    post("r103_red", er[0], 25);
`endif
    ack();
    begin_est();
    send(v4(10, 20, 30, 41), v4(0, 0, 0, 0), v4(0, 0, 0, 0), 7'h7f, -1);
    wait_done(lat);
    post("r101_red", er[0], 25);
    ack();

    // Gapped sum_valid with Start pulsed mid-accumulation.
    begin_est();
    send(v4(10, 20, 30, 40), v4(0, 0, 0, 0), v4(255, 255, 255, 255), 7'b1011001, 2);
    wait_done(lat);
    post("gap_latency", lat, 33);
    post("gap_red", er[0], 25);
    post("gap_blue", eb[0], 255);
    ack();

    // Reset while dividing green.
    begin_est();
    send(v4(10, 20, 30, 40), v4(0, 0, 0, 0), v4(255, 255, 255, 255), 7'h7f, -1);
    repeat (14) @(posedge Clk);
    #2 Reset_n = 1'b0;
    #1;
    post("mid_rst_qi", fl[0][0], 1);
    post("mid_rst_qg", fl[0][3], 0);
    post("mid_rst_done", fl[0][6], 0);
    post("mid_rst_red", er[0], 0);
    @(negedge Clk); Reset_n = 1'b1;
    begin_est();
    send(v4(10, 20, 30, 40), v4(0, 0, 0, 0), v4(255, 255, 255, 255), 7'h7f, -1);
    wait_done(lat);
    post("post_rst_red", er[0], 25);
    post("post_rst_blue", eb[0], 255);

    // Start together with Ack in DONE returns to IDLE, results held.
    @(negedge Clk); Start = 1'b1; Ack = 1'b1;
    @(negedge Clk); Start = 1'b0; Ack = 1'b0;
    post("sa_qi", fl[0][0], 1);
    post("sa_qa", fl[0][1], 0);
    post("sa_red", er[0], 25);
    @(negedge Clk);
    post("sa_qi_hold", fl[0][0], 1);

    // Wide build: 4*16320/256 = 255 exactly.
    begin_est();
    send(v4(16320, 16320, 16320, 16320), v4(16320, 16320, 16320, 16320),
         v4(16320, 16320, 16320, 16320), 7'h7f, -1);
    wait_done(lat);
    post("wide_red", er[1], 255);
    post("wide_green", eg[1], 255);
    post("wide_blue", eb[1], 255);
    ack();

    // Saturation: 4000/4 = 1000 clamps to 255; 8-bit build sees 232s.
    begin_est();
    send(v4(1000, 1000, 1000, 1000), v4(1000, 1000, 1000, 1000),
         v4(1000, 1000, 1000, 1000), 7'h7f, -1);
    wait_done(lat);
    post("sat_red", er[2], 255);
    post("sat_blue", eb[2], 255);
    post("sat_a_red", er[0], 232);
    ack();

    repeat (2) @(negedge Clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
